muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Iterative multiply/divide unit with its own sequencer and the architectural HI/LO register pair. It sits beside the ALU in the execute stage and services MULT/MULTU/DIV/DIVU plus MTHI/MTLO. It reports `busy` so the pipeline stalls any HI/LO access or new mul/div issue until the result is written.

## Interface
- Parameters: none. The datapath is fixed at 32 bits.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: issue strobe, sampled on a rising edge.
- `op` in 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops.
- `a` in 32: rs operand (multiplicand/dividend; source for MTHI/MTLO).
- `b` in 32: rt operand (multiplier/divisor).
- `busy` out 1: high while state ≠ IDLE.
- `done` out 1: registered one-cycle pulse when HI/LO receive a mul/div result.
- `div_zero` out 1: registered; high with `done` when a DIV/DIVU had `b`=0.
- `hi` out 32, `lo` out 32: architectural HI/LO registers.

## Operation
- States: IDLE, PREP, RUN, FIX. A 5-bit iteration counter `cnt` runs during RUN.
- IDLE + `start` + mul/div op: latch op and signedness, go to PREP.
  - For signed ops, latch |a| and |b|, plus neg_q = a[31]^b[31] and neg_r = a[31].
  - For unsigned ops, latch a and b directly; neg_q = neg_r = 0.
- IDLE + `start` + MTHI/MTLO: write `hi` (or `lo`) = `a` on that edge. State stays IDLE; `busy`, `done` and `div_zero` are not asserted.
- IDLE + `start` + op 110/111: ignored.
- `start` while `busy`: ignored entirely. The pipeline guarantees it is stalled, and the block must not depend on that.
- PREP:
  - Divide with zero divisor: go to FIX with the zero-divide flag set.
  - Otherwise: clear the 64-bit accumulator/remainder, set `cnt`=0, go to RUN.
- RUN, multiply: radix-2 shift-add on 32-bit magnitudes.
  - Each cycle, if the current multiplier LSB is 1, add the multiplicand to the upper half.
  - Then shift the 65-bit {carry,acc} right by 1.
- RUN, divide: restoring division.
  - Each cycle, shift {rem,quot} left by 1.
  - Trial-subtract the divisor from rem using a 33-bit subtract.
  - If non-negative, keep the difference and set the quotient LSB.
- RUN ends after exactly 32 iterations: at `cnt`==31, go to FIX.
- FIX, multiply: product P (64 bits) is negated if neg_q; {hi,lo} = P.
- FIX, divide: lo = neg_q ? −Q : Q and hi = neg_r ? −R : R. The quotient truncates toward zero; the remainder takes the dividend's sign.
- FIX, divide by zero: hi = `a` (as latched), lo = 32'hFFFF_FFFF, `div_zero`=1.
- FIX always returns to IDLE.
- All arithmetic is modulo 2^32/2^64; there is no overflow flag.
  - DIV 0x8000_0000 / 0xFFFF_FFFF yields lo=0x8000_0000, hi=0.
  - MULT of two most-negative values yields {hi,lo}=0x4000_0000_0000_0000.

## Timing
- Reset (async, any state): state=IDLE, `cnt`=0, `hi`=`lo`=0, `busy`=0, `done`=0, `div_zero`=0. Any in-flight operation is discarded and HI/LO are not partially written.
- Let E0 be the edge that samples `start`. `busy`=1 from just after E0.
- Normal mul/div:
  - PREP after E0, RUN from E1; iterations occur on E2..E33; FIX after E33.
  - E34 writes HI/LO and returns to IDLE.
  - `done` is high for the cycle after E34, and `busy` is 0 in that same cycle.
  - Latency is 34 cycles from E0 to visible result; `busy` is high for 34 cycles.
- Divide by zero: E1 → FIX; E2 writes HI/LO; `done`=`div_zero`=1 for the cycle after E2. Latency is 2 cycles.
- MTHI/MTLO: the new value is visible in the cycle after E0, with zero stall.
- Back-to-back: `start` may be asserted in the same cycle `done` is high (state IDLE). It is accepted, and the new op begins with no bubble.
- `hi`/`lo` outputs never change except at FIX edges, MTHI/MTLO edges, or reset.
- `a`/`b` need only be valid at E0, since operands are latched. The latched `a` is retained for the divide-by-zero HI value.

## Test plan
- MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF → `done` 34 cycles after E0; hi=0xFFFF_FFFE, lo=0x0000_0001; `busy` high exactly 34 cycles.
- MULT a=−3 (0xFFFF_FFFD), b=7 → hi=0xFFFF_FFFF, lo=0xFFFF_FFEB. MULT 0x8000_0000×0x8000_0000 → hi=0x4000_0000, lo=0.
- DIV a=−7, b=2 → lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIVU a=7, b=2 → lo=3, hi=1. DIV 0x8000_0000 / 0xFFFF_FFFF → lo=0x8000_0000, hi=0.
- DIVU a=100, b=0 → `done`=`div_zero`=1 two cycles after E0; hi=0x64, lo=0xFFFF_FFFF. The next normal op clears `div_zero`.
- MTHI a=0x1234 in IDLE → hi=0x1234 next cycle, no `busy`/`done`. MTLO issued mid-MULT is ignored: lo equals the product lo. A start issued in the `done` cycle is accepted.
- Assert `reset` at iteration 10 of a DIV → immediately hi=lo=0, `busy`=0. A new MULTU 6×7 after deassert → lo=42, hi=0, `done` after 34 cycles.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - iterative multiply/divide sequencer with architectural HI/LO pair
module muldiv_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        RUN  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [4:0]  cnt;

    // Operation context captured at issue.
    logic        is_div;
    logic        neg_q;
    logic        neg_r;
    logic        dz;
    logic [31:0] a_raw;
    logic [31:0] mag_a;   // multiplicand / dividend magnitude
    logic [31:0] mag_b;   // multiplier / divisor magnitude

    // Multiply: {upper partial product, remaining multiplier bits}.
    // Divide:   {remainder, quotient/dividend bits}.
    logic [63:0] acc;

    logic        issue_muldiv;
    logic        signed_op;
    logic        prep_divz;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [63:0] div_shift;
    logic [32:0] div_trial;
    logic [63:0] div_next;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign busy         = (state != IDLE);
    assign issue_muldiv = (state == IDLE) && start && !op[2];
    assign signed_op    = !op[0];
    assign prep_divz    = is_div && (mag_b == 32'd0);

    // Radix-2 shift-add: conditionally add multiplicand to the top half, then shift the carry in.
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_a} : 33'd0);
    assign mul_next = {mul_sum, acc[31:1]};

    // Restoring divide: the bit shifted out of the remainder takes part in the 33-bit trial.
    assign div_shift = {acc[62:0], 1'b0};
    assign div_trial = {acc[63], div_shift[63:32]} - {1'b0, mag_b};
    assign div_next  = div_trial[32] ? div_shift : {div_trial[31:0], div_shift[31:1], 1'b1};

    // Sign restoration applied when results are committed.
    assign prod_fix = neg_q ? (~acc + 64'd1) : acc;
    assign quo_fix  = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
    assign rem_fix  = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state sequencing.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (issue_muldiv) begin
                    next_state = PREP;
                end
            end
            PREP: begin
                next_state = prep_divz ? FIX : RUN;
            end
            RUN: begin
                if (cnt == 5'd31) begin
                    next_state = FIX;
                end
            end
            FIX: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, iteration, HI/LO commit and result strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= 5'd0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            a_raw    <= 32'd0;
            mag_a    <= 32'd0;
            mag_b    <= 32'd0;
            acc      <= 64'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue_muldiv) begin
                        is_div <= op[1];
                        a_raw  <= a;
                        mag_a  <= (signed_op && a[31]) ? (~a + 32'd1) : a;
                        mag_b  <= (signed_op && b[31]) ? (~b + 32'd1) : b;
                        neg_q  <= signed_op && (a[31] ^ b[31]);
                        neg_r  <= signed_op && a[31];
                    end else if (start && (op == OP_MTHI)) begin
                        hi <= a;
                    end else if (start && (op == OP_MTLO)) begin
                        lo <= a;
                    end
                end
                PREP: begin
                    // Upper half starts clear; lower half holds the bits consumed by the iterations.
                    dz  <= prep_divz;
                    acc <= is_div ? {32'd0, mag_a} : {32'd0, mag_b};
                    cnt <= 5'd0;
                end
                RUN: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt + 5'd1;
                end
                FIX: begin
                    done     <= 1'b1;
                    div_zero <= dz;
                    if (dz) begin
                        hi <= a_raw;
                        lo <= 32'hFFFF_FFFF;
                    end else if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end
                end
                default: begin
                    cnt <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed scoreboard bench for muldiv_ctrl
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        logic [7:0]  lat;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    muldiv_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t               e;
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        logic signed [63:0] sr;
        logic        [63:0] ur;
        e    = '0;
        e.lat = 8'd34;
        sx   = {{32{x[31]}}, x};
        sy   = {{32{y[31]}}, y};
        case (o)
            3'd0: begin
                sr = sx * sy;
                e.hi = sr[63:32];
                e.lo = sr[31:0];
            end
            3'd1: begin
                ur = {32'd0, x} * {32'd0, y};
                e.hi = ur[63:32];
                e.lo = ur[31:0];
            end
            3'd2: begin
                if (y == 32'd0) begin
                    e.hi = x; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1; e.lat = 8'd2;
                end else begin
                    sr = sx / sy;
                    e.lo = sr[31:0];
                    sr = sx % sy;
                    e.hi = sr[31:0];
                end
            end
            default: begin
                if (y == 32'd0) begin
                    e.hi = x; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1; e.lat = 8'd2;
                end else begin
                    e.lo = x / y;
                    e.hi = x % y;
                end
            end
        endcase
        return e;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one issue cycle; mul/div expectations go to the scoreboard, operands are then scrambled.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        if (!o[2]) sb.push_back(model(o, x, y));
        tick;
        start = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
    endtask

    task automatic issue_mt(input string tag, input logic is_lo, input logic [31:0] x);
        issue(is_lo ? 3'b101 : 3'b100, x, 32'd0);
        if (is_lo) exp_lo = x; else exp_hi = x;
        check32({tag, "_hi"}, hi, exp_hi);
        check32({tag, "_lo"}, lo, exp_lo);
        check1({tag, "_busy"}, busy, 1'b0);
        check1({tag, "_done"}, done, 1'b0);
    endtask

    // Wait for done (bounded), then compare against the scoreboard head.
    task automatic wait_result(input string tag, input int e0);
        int   e;
        int   nbusy;
        exp_t x;
        e = e0;
        nbusy = e0;
        if (e0 == 0) check1({tag, "_done_e0"}, done, 1'b0);
        while (!done && e < 60) begin
            if (busy) nbusy++;
            tick;
            e++;
        end
        x = (sb.size() != 0) ? sb.pop_front() : '0;
        check32({tag, "_latency"}, 32'(e), 32'(x.lat));
        check32({tag, "_busy_cycles"}, 32'(nbusy), 32'(x.lat));
        check1({tag, "_busy_at_done"}, busy, 1'b0);
        check32({tag, "_hi"}, hi, x.hi);
        check32({tag, "_lo"}, lo, x.lo);
        check1({tag, "_div_zero"}, div_zero, x.dz);
        exp_hi = x.hi;
        exp_lo = x.lo;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_dz", div_zero, 1'b0);
        check32("rst_hi", hi, 32'd0);
        check32("rst_lo", lo, 32'd0);
        reset = 1'b0;
        tick;

        issue_mt("mthi", 1'b0, 32'h0000_1234);
        issue_mt("mtlo", 1'b1, 32'h0000_5678);

        issue(3'b110, 32'hFFFF_FFFF, 32'd3);
        check1("nop6_busy", busy, 1'b0);
        check32("nop6_hi", hi, exp_hi);
        check32("nop6_lo", lo, exp_lo);
        issue(3'b111, 32'hFFFF_FFFF, 32'd3);
        check1("nop7_busy", busy, 1'b0);
        check32("nop7_lo", lo, exp_lo);

        // Back-to-back chain: each issue happens in the done cycle of the previous op.
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check32("multu_hold_hi", hi, 32'h0000_1234);
        wait_result("multu_max", 0);
        check32("multu_max_hi_const", hi, 32'hFFFF_FFFE);
        check32("multu_max_lo_const", lo, 32'h0000_0001);
        issue(3'd0, 32'hFFFF_FFFD, 32'd7);
        check1("b2b_busy", busy, 1'b1);
        wait_result("mult_neg3x7", 0);
        issue(3'd0, 32'h8000_0000, 32'h8000_0000);
        wait_result("mult_minmin", 0);
        check32("mult_minmin_hi_const", hi, 32'h4000_0000);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_result("div_neg7_2", 0);
        check32("div_neg7_2_lo_const", lo, 32'hFFFF_FFFD);
        issue(3'd3, 32'd7, 32'd2);
        wait_result("divu_7_2", 0);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("div_ovf", 0);
        check32("div_ovf_lo_const", lo, 32'h8000_0000);
        issue(3'd3, 32'd100, 32'd0);
        wait_result("divu_zero", 0);
        check32("divu_zero_hi_const", hi, 32'h0000_0064);
        issue(3'd2, 32'h1234_5678, 32'd0);
        wait_result("div_zero_signed", 0);
        issue(3'd1, 32'd5, 32'd9);
        wait_result("multu_clear_dz", 0);

        for (int i = 0; i < 6; i++) begin
            issue(3'($urandom_range(0, 3)), $urandom, (i == 2) ? 32'($urandom_range(1, 15)) : $urandom);
            wait_result($sformatf("rand%0d", i), 0);
        end

        // MTLO and a DIVU issued while busy must both be ignored.
        issue(3'd0, 32'h0001_2345, 32'hFFFF_F777);
        repeat (5) tick;
        start = 1'b1; op = 3'b101; a = 32'hDEAD_BEEF;
        tick;
        check32("mtlo_busy_lo", lo, exp_lo);
        op = 3'd3; a = 32'd9; b = 32'd0;
        tick;
        start = 1'b0;
        check1("busy_start_ignored", busy, 1'b1);
        wait_result("mult_with_mtlo", 7);

        // Asynchronous reset partway through a divide.
        issue(3'd2, 32'h7000_0000, 32'd3);
        repeat (11) tick;
        check1("pre_reset_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check1("midrst_busy", busy, 1'b0);
        check32("midrst_hi", hi, 32'd0);
        check32("midrst_lo", lo, 32'd0);
        sb.delete();
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        tick;
        check1("midrst_done", done, 1'b0);
        reset = 1'b0;
        tick;
        issue(3'd1, 32'd6, 32'd7);
        wait_result("multu_after_rst", 0);
        check32("multu_after_rst_lo_const", lo, 32'd42);
        tick;
        check1("done_pulse_end", done, 1'b0);
        check32("idle_hold_hi", hi, exp_hi);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
